song_player_ctrl: RTL and testbench

Playback controller that sequences the song note ROMs for the buzzer path. It owns the play/pause/stop state machine, selects one of up to four song ROMs, steps the note address once per beat, and inserts an articulation gap at the end of every beat. It drives one registered 5-bit note code to the tone generator. It sits between the debounced front-panel buttons and the song ROMs / tone generator.

---
 rtl/song_player_ctrl_pkg.sv | 34 +++
 rtl/song_player_ctrl_beat_timer.sv | 42 ++++
 rtl/song_player_ctrl.sv | 126 ++++++++++++
 tb/tb_song_player_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/song_player_ctrl_pkg.sv
// Shared definitions for the buzzer playback path: player state encodings,
// note-code layout and the song ROM bus helper. The tone generator and the
// song ROMs import this package as well.
// Note codes: 0 = silence, 1..21 = low/mid/high register tones.
package song_player_ctrl_pkg;

  typedef enum logic [1:0] {
    sstop  = 2'b00,
    splay  = 2'b01,
    spause = 2'b10
  } play_state_t;

  localparam int NOTE_W    = 5;
  localparam int NUM_SONGS = 4;
  localparam int ADDR_W    = 6;

  localparam logic [NOTE_W-1:0] NOTE_SILENCE = 5'd0;

  // Pick one song's note code out of the packed ROM bus (song k on bits [5k+4:5k])
  function automatic logic [NOTE_W-1:0] select_note(
    input logic [NUM_SONGS*NOTE_W-1:0] bus,
    input logic [1:0]                  idx
  );
    logic [NOTE_W-1:0] n;
    case (idx)
      2'd0:    n = bus[0*NOTE_W +: NOTE_W];
      2'd1:    n = bus[1*NOTE_W +: NOTE_W];
      2'd2:    n = bus[2*NOTE_W +: NOTE_W];
      default: n = bus[3*NOTE_W +: NOTE_W];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/song_player_ctrl_beat_timer.sv
// Beat timer: counts 0..BEAT_TICKS-1 while enabled and wraps, can be frozen
// by hold or forced back to zero by clear. Flags the first cycle of a beat,
// the trailing silent gap and the last cycle of a beat.
module song_player_ctrl_beat_timer #(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  input  logic enable,
  output logic at_start,
  output logic in_gap,
  output logic at_end
);

  localparam int CNT_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_START = CNT_W'(BEAT_TICKS - GAP_TICKS);

  logic [CNT_W-1:0] count;

  // Beat counter: clear wins over hold, hold wins over counting
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !hold) begin
      count <= at_end ? '0 : count + CNT_W'(1);
    end
  end

  // Decode the beat position flags; a zero-length gap never reports in_gap
  always_comb begin
    at_start = (count == '0);
    at_end   = (count == LAST_CNT);
    in_gap   = (GAP_TICKS != 0) && (count >= GAP_START);
  end

endmodule

// File: rtl/song_player_ctrl.sv
// Playback controller for the buzzer: play/pause/stop FSM, song selection,
// per-beat note address stepping and the articulation gap at the end of
// each beat. Every output leaves through a register.
import song_player_ctrl_pkg::*;

module song_player_ctrl #(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000,
  parameter int SONG_LEN   = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_play,
  input  logic                          btn_pause,
  input  logic                          btn_stop,
  input  logic [1:0]                    song_sel,
  input  logic                          loop_en,
  input  logic [NUM_SONGS*NOTE_W-1:0]   rom_note,
  output logic [ADDR_W-1:0]             rom_addr,
  output logic [1:0]                    state,
  output logic [1:0]                    song_id,
  output logic [NOTE_W-1:0]             note_out,
  output logic                          beat_strobe,
  output logic                          done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  play_state_t         cur_state;
  play_state_t         nxt_state;
  logic                at_start;
  logic                in_gap;
  logic                at_end;
  logic                start_play;
  logic                advancing;
  logic                last_note;
  logic                timer_clear;
  logic                timer_hold;
  logic                timer_enable;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [1:0]          nxt_song_id;
  logic [NOTE_W-1:0]   nxt_note;
  logic                nxt_strobe;
  logic                nxt_done;

  song_player_ctrl_beat_timer #(
    .BEAT_TICKS (BEAT_TICKS),
    .GAP_TICKS  (GAP_TICKS)
  ) u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .hold     (timer_hold),
    .enable   (timer_enable),
    .at_start (at_start),
    .in_gap   (in_gap),
    .at_end   (at_end)
  );

  // Register the FSM state together with all outputs; reset beats everything
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= sstop;
      rom_addr    <= '0;
      song_id     <= '0;
      note_out    <= NOTE_SILENCE;
      beat_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      rom_addr    <= nxt_addr;
      song_id     <= nxt_song_id;
      note_out    <= nxt_note;
      beat_strobe <= nxt_strobe;
      done        <= nxt_done;
    end
  end

  // Next-state logic; stop outranks pause, pause outranks play, and a
  // command that means nothing in the current state is simply ignored
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      sstop: begin
        if (btn_play && !btn_stop) nxt_state = splay;
      end
      splay: begin
        if (btn_stop)                                nxt_state = sstop;
        else if (btn_pause)                          nxt_state = spause;
        else if (at_end && last_note && !loop_en)    nxt_state = sstop;
      end
      spause: begin
        if (btn_stop)      nxt_state = sstop;
        else if (btn_play) nxt_state = splay;
      end
      default: nxt_state = sstop;
    endcase
  end

  // Datapath controls and next output values; a beat only advances in PLAY
  // when no pause or stop arrives in the same cycle, so those commands
  // silence the output and freeze the counter on the edge that samples them
  always_comb begin
    start_play   = (cur_state == sstop) && btn_play && !btn_stop;
    advancing    = (cur_state == splay) && !btn_stop && !btn_pause;
    last_note    = (rom_addr == LAST_ADDR);
    timer_clear  = start_play || btn_stop;
    timer_hold   = !advancing;
    timer_enable = (cur_state == splay);

    nxt_addr = rom_addr;
    if (btn_stop || start_play) begin
      nxt_addr = '0;
    end else if (advancing && at_end) begin
      nxt_addr = last_note ? '0 : rom_addr + ADDR_W'(1);
    end

    nxt_song_id = start_play ? song_sel : song_id;
    nxt_note    = (advancing && !in_gap) ? select_note(rom_note, song_id) : NOTE_SILENCE;
    nxt_strobe  = advancing && at_start;
    nxt_done    = advancing && at_end && last_note;
  end

  assign state = cur_state;

endmodule

// File: tb/tb_song_player_ctrl.sv
// Directed bench for song_player_ctrl with 8-cycle beats, a 2-cycle gap and
// 4-note songs. The ROMs are small lookup tables driven from rom_addr.
module tb_song_player_ctrl;

  logic        clk;
  logic        reset;
  logic        btn_play;
  logic        btn_pause;
  logic        btn_stop;
  logic [1:0]  song_sel;
  logic        loop_en;
  logic [19:0] rom_note;
  logic [5:0]  rom_addr;
  logic [1:0]  state;
  logic [1:0]  song_id;
  logic [4:0]  note_out;
  logic        beat_strobe;
  logic        done;

  int check_count = 0;
  int pass_count  = 0;

  logic [4:0] song0 [4] = '{5'd1,  5'd2,  5'd3,  5'd4};
  logic [4:0] song1 [4] = '{5'd13, 5'd14, 5'd13, 5'd12};
  logic [4:0] song2 [4] = '{5'd5,  5'd6,  5'd7,  5'd8};
  logic [4:0] song3 [4] = '{5'd21, 5'd20, 5'd19, 5'd18};

  song_player_ctrl #(
    .BEAT_TICKS (8),
    .GAP_TICKS  (2),
    .SONG_LEN   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_play    (btn_play),
    .btn_pause   (btn_pause),
    .btn_stop    (btn_stop),
    .song_sel    (song_sel),
    .loop_en     (loop_en),
    .rom_note    (rom_note),
    .rom_addr    (rom_addr),
    .state       (state),
    .song_id     (song_id),
    .note_out    (note_out),
    .beat_strobe (beat_strobe),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM model: combinational lookup at the shared address
  always_comb begin
    rom_note = '0;
    if (rom_addr < 6'd4)
      rom_note = {song3[rom_addr[1:0]], song2[rom_addr[1:0]],
                  song1[rom_addr[1:0]], song0[rom_addr[1:0]]};
  end

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of button pulses, sampled at the next edge
  task automatic applyStimulus(input logic play, input logic pause, input logic stop);
    btn_play  = play;
    btn_pause = pause;
    btn_stop  = stop;
    tick();
    btn_play  = 1'b0;
    btn_pause = 1'b0;
    btn_stop  = 1'b0;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Directed scenario sequence
  initial begin
    reset = 1'b1; btn_play = 1'b0; btn_pause = 1'b0; btn_stop = 1'b0;
    song_sel = 2'd0; loop_en = 1'b0;
    tick(); tick();
    $display("[TB] reset state");
    checkOutput("rst_state",  state,       2'd0);
    checkOutput("rst_addr",   rom_addr,    6'd0);
    checkOutput("rst_song",   song_id,     2'd0);
    checkOutput("rst_note",   note_out,    5'd0);
    checkOutput("rst_strobe", beat_strobe, 1'b0);
    checkOutput("rst_done",   done,        1'b0);
    reset = 1'b0;

    $display("[TB] basic play, no loop");
    song_sel = 2'd1; loop_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("play_state", state,    2'd1);
    checkOutput("play_song",  song_id,  2'd1);
    checkOutput("play_note0", note_out, 5'd0);
    tick();
    checkOutput("first_note",   note_out,    5'd13);
    checkOutput("first_strobe", beat_strobe, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("beat0_note",   note_out,    5'd13);
      checkOutput("beat0_strobe", beat_strobe, 1'b0);
    end
    tick();
    checkOutput("gap_note_a", note_out, 5'd0);
    tick();
    checkOutput("gap_note_b", note_out, 5'd0);
    checkOutput("addr_step",  rom_addr, 6'd1);
    tick();
    checkOutput("beat1_note",   note_out,    5'd14);
    checkOutput("beat1_strobe", beat_strobe, 1'b1);
    repeat (15) tick();
    tick();
    checkOutput("beat3_note",   note_out,    5'd12);
    checkOutput("beat3_strobe", beat_strobe, 1'b1);
    checkOutput("beat3_addr",   rom_addr,    6'd3);
    repeat (6) tick();
    checkOutput("pre_end_done",  done,  1'b0);
    checkOutput("pre_end_state", state, 2'd1);
    tick();
    checkOutput("end_done",  done,     1'b1);
    checkOutput("end_state", state,    2'd0);
    checkOutput("end_addr",  rom_addr, 6'd0);
    checkOutput("end_note",  note_out, 5'd0);
    tick();
    checkOutput("end_done_once", done,  1'b0);
    checkOutput("end_stays",     state, 2'd0);

    $display("[TB] looping play with song_sel change");
    song_sel = 2'd1; loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    song_sel = 2'd3;
    checkOutput("loop_state", state, 2'd1);
    repeat (31) tick();
    tick();
    checkOutput("loop_done",  done,     1'b1);
    checkOutput("loop_state", state,    2'd1);
    checkOutput("loop_addr",  rom_addr, 6'd0);
    tick();
    checkOutput("loop_note",      note_out,    5'd13);
    checkOutput("loop_strobe",    beat_strobe, 1'b1);
    checkOutput("loop_done_once", done,        1'b0);
    checkOutput("song_held",      song_id,     2'd1);

    $display("[TB] pause and resume");
    repeat (18) tick();
    checkOutput("prepause_addr", rom_addr, 6'd2);
    checkOutput("prepause_note", note_out, 5'd13);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pause_state",  state,       2'd2);
    checkOutput("pause_note",   note_out,    5'd0);
    checkOutput("pause_strobe", beat_strobe, 1'b0);
    repeat (20) tick();
    checkOutput("paused_state", state,    2'd2);
    checkOutput("paused_addr",  rom_addr, 6'd2);
    checkOutput("paused_note",  note_out, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_state", state,    2'd1);
    checkOutput("resume_note0", note_out, 5'd0);
    tick();
    checkOutput("resume_note",   note_out,    5'd13);
    checkOutput("resume_strobe", beat_strobe, 1'b0);
    tick(); tick();
    checkOutput("resume_note_c5", note_out, 5'd13);
    tick();
    checkOutput("resume_gap",  note_out, 5'd0);
    checkOutput("resume_hold", rom_addr, 6'd2);
    tick();
    checkOutput("resume_addr", rom_addr, 6'd3);
    tick();
    checkOutput("resume_next_note",   note_out,    5'd12);
    checkOutput("resume_next_strobe", beat_strobe, 1'b1);

    $display("[TB] coincident commands");
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("all_cmd_state", state,    2'd0);
    checkOutput("all_cmd_addr",  rom_addr, 6'd0);
    checkOutput("all_cmd_note",  note_out, 5'd0);
    song_sel = 2'd2;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stop_playpause_state", state,   2'd1);
    checkOutput("stop_playpause_song",  song_id, 2'd2);
    tick();
    checkOutput("song2_note",   note_out,    5'd5);
    checkOutput("song2_strobe", beat_strobe, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("play_playpause_state", state,    2'd2);
    checkOutput("play_playpause_note",  note_out, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pause_stop_state", state, 2'd0);

    $display("[TB] reset mid-operation");
    song_sel = 2'd1; loop_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (7) tick();
    checkOutput("ingap_note",  note_out, 5'd0);
    checkOutput("ingap_state", state,    2'd1);
    reset = 1'b1;
    tick();
    checkOutput("gap_rst_state",  state,       2'd0);
    checkOutput("gap_rst_song",   song_id,     2'd0);
    checkOutput("gap_rst_addr",   rom_addr,    6'd0);
    checkOutput("gap_rst_note",   note_out,    5'd0);
    checkOutput("gap_rst_strobe", beat_strobe, 1'b0);
    checkOutput("gap_rst_done",   done,        1'b0);
    reset = 1'b0;
    song_sel = 2'd3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("song3_note",   note_out,    5'd21);
    checkOutput("song3_strobe", beat_strobe, 1'b1);
    repeat (8) tick();
    checkOutput("song3_addr",  rom_addr, 6'd1);
    checkOutput("song3_note1", note_out, 5'd20);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("song3_pause", state, 2'd2);
    reset = 1'b1;
    tick();
    checkOutput("pause_rst_state", state,    2'd0);
    checkOutput("pause_rst_song",  song_id,  2'd0);
    checkOutput("pause_rst_addr",  rom_addr, 6'd0);
    checkOutput("pause_rst_note",  note_out, 5'd0);
    reset = 1'b0;
    song_sel = 2'd1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("restart_note",   note_out,    5'd13);
    checkOutput("restart_addr",   rom_addr,    6'd0);
    checkOutput("restart_strobe", beat_strobe, 1'b1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
